// File: rtl/pe_multimode_faulty.sv
`default_nettype none
// ============================================================================
// Module      : pe_multimode_faulty
// Description : Systolic-array processing element with a double-buffered
//               stationary operand and a built-in fault injector.
//               out_sum <= in_sum + stream * stationary (registered, modulo
//               2^ACC_W). A small FSM opens a fault window, counted in clk
//               cycles, during which a bit-flip or stuck-at mask is applied to
//               one target: the stream operand, the stationary read path, or
//               the registered psum.
//
// Ports       : clk, rst        - clock, synchronous active-high reset
//               in_stream       - horizontal streamed operand (D_W)
//               in_vert         - vertical stationary-fill operand (D_W)
//               in_sum          - incoming partial sum (ACC_W)
//               valid_in        - qualifies in_stream / in_sum
//               load_en         - write in_vert into the shadow bank
//               swap            - exchange active and shadow banks
//               out_stream      - registered effective stream operand
//               out_vert        - registered in_vert
//               out_sum         - registered psum (0 when valid_in = 0)
//               out_valid       - registered valid_in
//               fault_arm       - latch fault config, start the window
//               fault_disarm    - return the fault FSM to IDLE
//               fault_target    - 0 stream, 1 stationary, 2 psum, 3 none
//               fault_type      - 0 flip, 1 stuck-at-0, 2 stuck-at-1, 3 none
//               fault_mask      - bit mask (low D_W bits for operands)
//               fault_start     - cycles from arm to window open
//               fault_dur       - window length in cycles, 0 = permanent
//               fault_active    - fault FSM in ACTIVE
//               fault_done      - fault FSM in DONE
//
// Revision    : 1.0 - initial release
// ============================================================================
module pe_multimode_faulty #(
  parameter int D_W    = 8,
  parameter int ACC_W  = 16,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 16,
  parameter int ROW    = 0,
  parameter int COL    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [D_W-1:0]   in_stream,
  input  logic [D_W-1:0]   in_vert,
  input  logic [ACC_W-1:0] in_sum,
  input  logic             valid_in,
  input  logic             load_en,
  input  logic             swap,
  output logic [D_W-1:0]   out_stream,
  output logic [D_W-1:0]   out_vert,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_valid,
  input  logic             fault_arm,
  input  logic             fault_disarm,
  input  logic [1:0]       fault_target,
  input  logic [1:0]       fault_type,
  input  logic [ACC_W-1:0] fault_mask,
  input  logic [CNT_W-1:0] fault_start,
  input  logic [CNT_W-1:0] fault_dur,
  output logic             fault_active,
  output logic             fault_done
);

  // ROW/COL only tag this PE inside an array; they do not change behaviour.
  localparam int c_unused_pos = ROW + COL;

  localparam logic [1:0] c_TGT_STREAM = 2'd0;
  localparam logic [1:0] c_TGT_STAT   = 2'd1;
  localparam logic [1:0] c_TGT_PSUM   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ACTIVE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Fault function: x transformed by mask m according to fault type t.
  // --------------------------------------------------------------------------
  function automatic logic [ACC_W-1:0] apply_fault(
    input logic [ACC_W-1:0] x,
    input logic [ACC_W-1:0] m,
    input logic [1:0]       t
  );
    case (t)
      2'd0:    apply_fault = x ^ m;
      2'd1:    apply_fault = x & ~m;
      2'd2:    apply_fault = x | m;
      default: apply_fault = x;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // State and latched fault configuration
  // --------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [1:0]       r_tgt;
  logic [1:0]       r_type;
  logic [ACC_W-1:0] r_mask;
  logic [CNT_W-1:0] r_start;
  logic [CNT_W-1:0] r_dur;

  logic [D_W-1:0]   r_bank [2];
  logic             r_sel;

  logic             w_fault_on;
  logic [D_W-1:0]   w_active_val;
  logic [D_W-1:0]   w_eff_stream;
  logic [D_W-1:0]   w_eff_stat;
  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W-1:0] w_sum_raw;
  logic [ACC_W-1:0] w_eff_psum;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Next-state logic. Arm has priority over disarm; both override the
  // per-state counting so a re-arm always restarts the window cleanly.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (fault_arm) begin
      w_cnt_nxt   = '0;
      w_state_nxt = (fault_start == '0) ? S_ACTIVE : S_ARMED;
    end else if (fault_disarm) begin
      w_cnt_nxt   = '0;
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_ARMED: begin
          if (w_cnt_inc == r_start) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_ACTIVE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        S_ACTIVE: begin
          // dur = 0 keeps the window open indefinitely.
          if (r_dur != '0) begin
            if (w_cnt_inc == r_dur) begin
              w_cnt_nxt   = '0;
              w_state_nxt = S_DONE;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tgt   <= '0;
      r_type  <= '0;
      r_mask  <= '0;
      r_start <= '0;
      r_dur   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (fault_arm) begin
        r_tgt   <= fault_target;
        r_type  <= fault_type;
        r_mask  <= fault_mask;
        r_start <= fault_start;
        r_dur   <= fault_dur;
      end
    end
  end

  assign fault_active = (r_state == S_ACTIVE);
  assign fault_done   = (r_state == S_DONE);
  assign w_fault_on   = fault_active;

  // --------------------------------------------------------------------------
  // Effective operands. The stationary fault acts on the read path only, so
  // the bank contents survive and reappear once the window closes.
  // --------------------------------------------------------------------------
  assign w_active_val = r_bank[r_sel];

  assign w_eff_stream = (w_fault_on && (r_tgt == c_TGT_STREAM))
                      ? D_W'(apply_fault(ACC_W'(in_stream), r_mask, r_type))
                      : in_stream;

  assign w_eff_stat   = (w_fault_on && (r_tgt == c_TGT_STAT))
                      ? D_W'(apply_fault(ACC_W'(w_active_val), r_mask, r_type))
                      : w_active_val;

  generate
    if (SIGNED != 0) begin : g_signed
      logic signed [2*D_W-1:0] w_sa;
      logic signed [2*D_W-1:0] w_sb;
      logic signed [2*D_W-1:0] w_p;
      assign w_sa       = (2*D_W)'($signed(w_eff_stream));
      assign w_sb       = (2*D_W)'($signed(w_eff_stat));
      assign w_p        = w_sa * w_sb;
      assign w_prod_ext = ACC_W'(w_p);
    end else begin : g_unsigned
      logic [2*D_W-1:0] w_p;
      assign w_p        = (2*D_W)'(w_eff_stream) * (2*D_W)'(w_eff_stat);
      assign w_prod_ext = ACC_W'(w_p);
    end
  endgenerate

  assign w_sum_raw  = in_sum + w_prod_ext;
  assign w_eff_psum = (w_fault_on && (r_tgt == c_TGT_PSUM))
                    ? apply_fault(w_sum_raw, r_mask, r_type)
                    : w_sum_raw;

  // --------------------------------------------------------------------------
  // Banks and registered outputs. With load_en and swap together the write
  // lands in the pre-swap shadow, which then becomes the active bank.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank[0]  <= '0;
      r_bank[1]  <= '0;
      r_sel      <= 1'b0;
      out_stream <= '0;
      out_vert   <= '0;
      out_sum    <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (load_en) begin
        r_bank[~r_sel] <= in_vert;
      end
      if (swap) begin
        r_sel <= ~r_sel;
      end
      out_stream <= w_eff_stream;
      out_vert   <= in_vert;
      out_valid  <= valid_in;
      out_sum    <= valid_in ? w_eff_psum : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_multimode_faulty.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_multimode_faulty
// Description : Directed self-checking bench. Two PEs (unsigned and signed)
//               share one stimulus stream; expected values are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_multimode_faulty;

  localparam int D_W   = 8;
  localparam int ACC_W = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [D_W-1:0]   in_stream;
  logic [D_W-1:0]   in_vert;
  logic [ACC_W-1:0] in_sum;
  logic             valid_in;
  logic             load_en;
  logic             swap;
  logic             fault_arm;
  logic             fault_disarm;
  logic [1:0]       fault_target;
  logic [1:0]       fault_type;
  logic [ACC_W-1:0] fault_mask;
  logic [CNT_W-1:0] fault_start;
  logic [CNT_W-1:0] fault_dur;

  logic [D_W-1:0]   u_stream, s_stream;
  logic [D_W-1:0]   u_vert,   s_vert;
  logic [ACC_W-1:0] u_sum,    s_sum;
  logic             u_valid,  s_valid;
  logic             u_act,    s_act;
  logic             u_done,   s_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pe_multimode_faulty #(.D_W(D_W), .ACC_W(ACC_W), .SIGNED(0), .CNT_W(CNT_W),
                        .ROW(0), .COL(0)) u_dut (
    .clk(clk), .rst(rst), .in_stream(in_stream), .in_vert(in_vert),
    .in_sum(in_sum), .valid_in(valid_in), .load_en(load_en), .swap(swap),
    .out_stream(u_stream), .out_vert(u_vert), .out_sum(u_sum),
    .out_valid(u_valid), .fault_arm(fault_arm), .fault_disarm(fault_disarm),
    .fault_target(fault_target), .fault_type(fault_type),
    .fault_mask(fault_mask), .fault_start(fault_start), .fault_dur(fault_dur),
    .fault_active(u_act), .fault_done(u_done)
  );

  pe_multimode_faulty #(.D_W(D_W), .ACC_W(ACC_W), .SIGNED(1), .CNT_W(CNT_W),
                        .ROW(0), .COL(1)) u_dut_s (
    .clk(clk), .rst(rst), .in_stream(in_stream), .in_vert(in_vert),
    .in_sum(in_sum), .valid_in(valid_in), .load_en(load_en), .swap(swap),
    .out_stream(s_stream), .out_vert(s_vert), .out_sum(s_sum),
    .out_valid(s_valid), .fault_arm(fault_arm), .fault_disarm(fault_disarm),
    .fault_target(fault_target), .fault_type(fault_type),
    .fault_mask(fault_mask), .fault_start(fault_start), .fault_dur(fault_dur),
    .fault_active(s_act), .fault_done(s_done)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_stream = '0; in_vert = '0; in_sum = '0; valid_in = 1'b0;
    load_en = 1'b0; swap = 1'b0; fault_arm = 1'b0; fault_disarm = 1'b0;
    fault_target = 2'd3; fault_type = 2'd3; fault_mask = '0;
    fault_start = '0; fault_dur = '0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check_val("rst_sum",    32'(u_sum),    32'h0);
    check_val("rst_valid",  32'(u_valid),  32'h0);
    check_val("rst_active", 32'(u_act),    32'h0);
    check_val("rst_done",   32'(u_done),   32'h0);

    // Load 3 into shadow, swap, compute 5*3+10
    load_en = 1'b1; in_vert = 8'd3; tick();
    load_en = 1'b0; swap = 1'b1; tick();
    swap = 1'b0; valid_in = 1'b1; in_stream = 8'd5; in_sum = 16'd10; tick();
    check_val("cmp_sum",    32'(u_sum),    32'd25);
    check_val("cmp_stream", 32'(u_stream), 32'd5);
    check_val("cmp_vert",   32'(u_vert),   32'd3);
    check_val("cmp_valid",  32'(u_valid),  32'd1);

    // Transient psum flip, start=2 dur=1; config inputs scrambled after arm
    fault_arm = 1'b1; fault_target = 2'd2; fault_type = 2'd0;
    fault_mask = 16'h0001; fault_start = 16'd2; fault_dur = 16'd1;
    tick();
    fault_arm = 1'b0; fault_target = 2'd0; fault_type = 2'd2;
    fault_mask = 16'hFFFF; fault_start = 16'd0; fault_dur = 16'd0;
    check_val("tr_sum0", 32'(u_sum), 32'd25);
    check_val("tr_act0", 32'(u_act), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_val($sformatf("tr_sum%0d", i), 32'(u_sum), (i == 3) ? 32'd24 : 32'd25);
      check_val($sformatf("tr_act%0d", i), 32'(u_act), (i == 2) ? 32'd1 : 32'd0);
    end
    check_val("tr_done", 32'(u_done), 32'd1);
    fault_disarm = 1'b1; tick(); fault_disarm = 1'b0;
    check_val("disarm_done", 32'(u_done), 32'd0);

    // Permanent stuck-at-1 on stationary read path
    in_stream = 8'd2; in_sum = 16'd0;
    fault_arm = 1'b1; fault_target = 2'd1; fault_type = 2'd2;
    fault_mask = 16'h0080; fault_start = 16'd0; fault_dur = 16'd0;
    tick(); fault_arm = 1'b0;
    check_val("sa1_act",  32'(u_act), 32'd1);
    check_val("sa1_pre",  32'(u_sum), 32'd6);
    tick();
    check_val("sa1_sum",  32'(u_sum), 32'd262);
    tick();
    check_val("sa1_hold", 32'(u_sum), 32'd262);
    fault_disarm = 1'b1; tick(); fault_disarm = 1'b0;
    check_val("sa1_idle", 32'(u_act), 32'd0);
    tick();
    check_val("sa1_clean", 32'(u_sum), 32'd6);

    // Simultaneous load and swap: shadow holds 4, then load 7 + swap
    valid_in = 1'b0;
    load_en = 1'b1; in_vert = 8'd4; tick();
    check_val("inval_sum", 32'(u_sum), 32'd0);
    in_vert = 8'd7; swap = 1'b1; tick();
    load_en = 1'b0; swap = 1'b0; valid_in = 1'b1; in_stream = 8'd2; tick();
    check_val("ls_active", 32'(u_sum), 32'd14);
    swap = 1'b1; tick(); swap = 1'b0;
    tick();
    check_val("ls_prior", 32'(u_sum), 32'd6);

    // Signed: stationary 0xFE (-2) times 3
    valid_in = 1'b0; load_en = 1'b1; swap = 1'b1; in_vert = 8'hFE; tick();
    load_en = 1'b0; swap = 1'b0; valid_in = 1'b1; in_stream = 8'd3; in_sum = 16'd0;
    tick();
    check_val("sg_sum",   32'(s_sum), 32'hFFFA);
    check_val("usg_sum",  32'(u_sum), 32'h02FA);
    fault_arm = 1'b1; fault_target = 2'd0; fault_type = 2'd0;
    fault_mask = 16'h0001; fault_start = 16'd0; fault_dur = 16'd0;
    tick(); fault_arm = 1'b0;
    tick();
    check_val("sg_fstream", 32'(s_stream), 32'h02);
    check_val("sg_fsum",    32'(s_sum),    32'hFFFC);
    check_val("usg_fsum",   32'(u_sum),    32'h01FC);

    // Reset during a permanent window
    rst = 1'b1; tick(); rst = 1'b0;
    check_val("mr_act",    32'(u_act),    32'd0);
    check_val("mr_sum",    32'(u_sum),    32'd0);
    check_val("mr_stream", 32'(u_stream), 32'd0);
    check_val("mr_vert",   32'(u_vert),   32'd0);
    check_val("mr_valid",  32'(u_valid),  32'd0);
    in_stream = 8'd5; in_sum = 16'h1234; in_vert = 8'd0; tick();
    check_val("mr_cmp_sum",    32'(u_sum),    32'h1234);
    check_val("mr_cmp_stream", 32'(u_stream), 32'd5);

    // Arm and disarm together: arm wins; dur=3 gives three active cycles
    fault_arm = 1'b1; fault_disarm = 1'b1; fault_target = 2'd3;
    fault_type = 2'd3; fault_start = 16'd0; fault_dur = 16'd3;
    tick(); fault_arm = 1'b0; fault_disarm = 1'b0;
    check_val("ad_act0", 32'(u_act), 32'd1);
    tick();
    check_val("ad_act1", 32'(u_act), 32'd1);
    tick();
    check_val("ad_act2", 32'(u_act), 32'd1);
    tick();
    check_val("ad_act3",  32'(u_act),  32'd0);
    check_val("ad_done3", 32'(u_done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
